// File: rtl/shift_register_chain.sv
// Parametrised chain of DEPTH registers, WIDTH bits each, with hold/shift/load/rotate
// modes, a selectable tap, a parallel view and a saturating fill counter.
module shift_register_chain #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      SEL_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned      CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clear,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       in_1,
  input  logic [WIDTH*DEPTH-1:0] load_data,
  input  logic [SEL_W-1:0]       tap_sel,
  output logic [WIDTH-1:0]       out_1,
  output logic [WIDTH-1:0]       tap_out,
  output logic [WIDTH*DEPTH-1:0] stages_out,
  output logic [CNT_W-1:0]       fill_cnt,
  output logic                   full
);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_SHIFT  = 2'b01,
    MODE_LOAD   = 2'b10,
    MODE_ROTATE = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      fill_cnt <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      fill_cnt <= '0;
    end else if (en) begin
      case (mode_e'(mode))
        MODE_SHIFT: begin
          stage[0] <= in_1;
          for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
          if (fill_cnt != DEPTH_CNT) fill_cnt <= fill_cnt + CNT_W'(1);
        end
        MODE_LOAD: begin
          for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= load_data[i*WIDTH +: WIDTH];
          fill_cnt <= DEPTH_CNT;
        end
        MODE_ROTATE: begin
          // With DEPTH=1 this writes stage[0] back to itself, i.e. hold.
          stage[0] <= stage[DEPTH-1];
          for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
        default: ;
      endcase
    end
  end

  assign out_1 = stage[DEPTH-1];
  assign full  = (fill_cnt == DEPTH_CNT);

  always_comb begin
    stages_out = '0;
    for (int unsigned i = 0; i < DEPTH; i++) stages_out[i*WIDTH +: WIDTH] = stage[i];
  end

  // Unmatched selects (tap_sel >= DEPTH) fall through to zero.
  always_comb begin
    tap_out = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (tap_sel == SEL_W'(i)) tap_out = stage[i];
  end

endmodule

// File: tb/tb_shift_register_chain.sv
// Bench for shift_register_chain: directed table, tap/async-reset sequences, and
// randomized traffic on three configurations checked against a packed-vector model.
module tb_shift_register_chain;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        clear = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  in_1 = 8'h00;
  logic [31:0] load_data = 32'h0;
  logic [23:0] load3;
  logic [1:0]  tap_sel = 2'd0;

  logic [7:0]  a_out, a_tap, b_out, b_tap, c_out, c_tap;
  logic [31:0] a_stages, b_stages;
  logic [23:0] c_stages;
  logic [2:0]  a_cnt, b_cnt;
  logic [1:0]  c_cnt;
  logic        a_full, b_full, c_full;

  assign load3 = load_data[23:0];

  always #5 clk = ~clk;

  shift_register_chain #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) dut_a (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .mode(mode), .in_1(in_1),
    .load_data(load_data), .tap_sel(tap_sel), .out_1(a_out), .tap_out(a_tap),
    .stages_out(a_stages), .fill_cnt(a_cnt), .full(a_full));

  shift_register_chain #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut_b (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .mode(mode), .in_1(in_1),
    .load_data(load_data), .tap_sel(tap_sel), .out_1(b_out), .tap_out(b_tap),
    .stages_out(b_stages), .fill_cnt(b_cnt), .full(b_full));

  shift_register_chain #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) dut_c (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .mode(mode), .in_1(in_1),
    .load_data(load3), .tap_sel(tap_sel), .out_1(c_out), .tap_out(c_tap),
    .stages_out(c_stages), .fill_cnt(c_cnt), .full(c_full));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: each chain is a packed vector, stage 0 in the low byte.
  int unsigned md [3]  = '{4, 4, 3};
  logic [7:0]  mrv [3] = '{8'hA5, 8'h00, 8'h00};
  logic [31:0] ms [3];
  int unsigned mc [3];

  function automatic logic [31:0] mask_of(int k);
    return (md[k] == 4) ? 32'hFFFF_FFFF : 32'h00FF_FFFF;
  endfunction

  function automatic logic [31:0] rv_fill(int k);
    logic [31:0] r = 32'h0;
    for (int i = 0; i < int'(md[k]); i++) r[i*8 +: 8] = mrv[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin ms[k] = rv_fill(k); mc[k] = 0; end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (clear) begin
        ms[k] = rv_fill(k); mc[k] = 0;
      end else if (en) begin
        case (mode)
          2'd1: begin
            ms[k] = ((ms[k] << 8) | {24'h0, in_1}) & mask_of(k);
            mc[k] = (mc[k] < md[k]) ? mc[k] + 1 : md[k];
          end
          2'd2: begin ms[k] = load_data & mask_of(k); mc[k] = md[k]; end
          2'd3: ms[k] = ((ms[k] << 8) | (ms[k] >> ((md[k] - 1) * 8))) & mask_of(k);
          default: ;
        endcase
      end
    end
  endtask

  function automatic logic [7:0] m_out(int k);
    return ms[k][(md[k]-1)*8 +: 8];
  endfunction

  function automatic logic [7:0] m_tap(int k);
    if (tap_sel < md[k]) return ms[k][tap_sel*8 +: 8];
    return 8'h00;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_all();
    chk("rand_a_out",    {24'h0, a_out},  {24'h0, m_out(0)});
    chk("rand_a_stages", a_stages,        ms[0]);
    chk("rand_a_cnt",    {29'h0, a_cnt},  mc[0]);
    chk("rand_a_full",   {31'h0, a_full}, {31'h0, mc[0] == md[0]});
    chk("rand_a_tap",    {24'h0, a_tap},  {24'h0, m_tap(0)});
    chk("rand_b_out",    {24'h0, b_out},  {24'h0, m_out(1)});
    chk("rand_b_stages", b_stages,        ms[1]);
    chk("rand_b_cnt",    {29'h0, b_cnt},  mc[1]);
    chk("rand_b_full",   {31'h0, b_full}, {31'h0, mc[1] == md[1]});
    chk("rand_b_tap",    {24'h0, b_tap},  {24'h0, m_tap(1)});
    chk("rand_c_out",    {24'h0, c_out},  {24'h0, m_out(2)});
    chk("rand_c_stages", {8'h0, c_stages}, ms[2]);
    chk("rand_c_cnt",    {30'h0, c_cnt},  mc[2]);
    chk("rand_c_full",   {31'h0, c_full}, {31'h0, mc[2] == md[2]});
    chk("rand_c_tap",    {24'h0, c_tap},  {24'h0, m_tap(2)});
  endtask

  typedef struct {
    logic        en;
    logic        clear;
    logic [1:0]  mode;
    logic [7:0]  din;
    logic [31:0] load;
    logic [7:0]  exp_out;
    logic [31:0] exp_stages;
    logic [2:0]  exp_cnt;
    logic        exp_full;
  } vec_t;

  vec_t vecs [13];
  logic [7:0] tap_exp [4];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 2'd1, 8'h01, 32'h0,        8'h00, 32'h0000_0001, 3'd1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'd1, 8'h02, 32'h0,        8'h00, 32'h0000_0102, 3'd2, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'd1, 8'h03, 32'h0,        8'h00, 32'h0001_0203, 3'd3, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 2'd1, 8'h04, 32'h0,        8'h01, 32'h0102_0304, 3'd4, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 2'd1, 8'h05, 32'h0,        8'h02, 32'h0203_0405, 3'd4, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 2'd2, 8'h00, 32'h44332211, 8'h44, 32'h4433_2211, 3'd4, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 2'd3, 8'h00, 32'h0,        8'h33, 32'h3322_1144, 3'd4, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 2'd3, 8'h00, 32'h0,        8'h22, 32'h2211_4433, 3'd4, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 2'd1, 8'hEE, 32'h0,        8'h22, 32'h2211_4433, 3'd4, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 2'd1, 8'hEE, 32'h0,        8'h22, 32'h2211_4433, 3'd4, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 2'd1, 8'hEE, 32'h0,        8'h22, 32'h2211_4433, 3'd4, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 2'd0, 8'h77, 32'hFFFFFFFF, 8'h22, 32'h2211_4433, 3'd4, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 2'd1, 8'h00, 32'h0,        8'h00, 32'h0000_0000, 3'd0, 1'b0};
    tap_exp = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Reset pulse between edges; outputs must follow without a clock edge.
    @(posedge clk); #2;
    rst = 1'b1; model_reset(); #1;
    chk("reset_a_out",    {24'h0, a_out}, 32'hA5);
    chk("reset_a_stages", a_stages,       32'hA5A5_A5A5);
    chk("reset_a_cnt",    {29'h0, a_cnt}, 32'h0);
    chk("reset_a_full",   {31'h0, a_full}, 32'h0);
    chk("reset_a_tap",    {24'h0, a_tap}, 32'hA5);
    chk("reset_b_stages", b_stages,       32'h0);
    #1 rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      en = vecs[i].en; clear = vecs[i].clear; mode = vecs[i].mode;
      in_1 = vecs[i].din; load_data = vecs[i].load;
      tick();
      chk($sformatf("vec%0d_out", i),    {24'h0, b_out},  {24'h0, vecs[i].exp_out});
      chk($sformatf("vec%0d_stages", i), b_stages,        vecs[i].exp_stages);
      chk($sformatf("vec%0d_cnt", i),    {29'h0, b_cnt},  {29'h0, vecs[i].exp_cnt});
      chk($sformatf("vec%0d_full", i),   {31'h0, b_full}, {31'h0, vecs[i].exp_full});
    end
    clear = 1'b0;

    // Tap select after a parallel load, including out-of-range on the 3-deep chain.
    en = 1'b1; mode = 2'd2; load_data = 32'h44332211;
    tick();
    en = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tap_sel = 2'(t); #1;
      chk($sformatf("tap_b_%0d", t), {24'h0, b_tap}, {24'h0, tap_exp[t]});
    end
    tap_sel = 2'd2; #1;
    chk("tap_c_2", {24'h0, c_tap}, 32'h33);
    tap_sel = 2'd3; #1;
    chk("tap_c_oob", {24'h0, c_tap}, 32'h0);

    // Async reset 1 ns after the third shift edge, then a single shift of 9.
    rst = 1'b1; model_reset(); #1 rst = 1'b0;
    en = 1'b1; mode = 2'd1;
    for (int s = 1; s <= 3; s++) begin in_1 = 8'(s); tick(); end
    chk("pre_rst_stages", b_stages, 32'h0001_0203);
    rst = 1'b1; model_reset(); #1;
    chk("async_rst_stages", b_stages,       32'h0);
    chk("async_rst_cnt",    {29'h0, b_cnt}, 32'h0);
    chk("async_rst_full",   {31'h0, b_full}, 32'h0);
    rst = 1'b0; in_1 = 8'h09;
    tick();
    chk("post_rst_stages", b_stages,       32'h0000_0009);
    chk("post_rst_cnt",    {29'h0, b_cnt}, 32'h1);

    // Randomized traffic on all three configurations.
    for (int n = 0; n < 400; n++) begin
      en        = ($urandom_range(0, 7) != 0);
      clear     = ($urandom_range(0, 19) == 0);
      mode      = 2'($urandom_range(0, 3));
      in_1      = 8'($urandom);
      load_data = $urandom;
      tap_sel   = 2'($urandom_range(0, 3));
      tick();
      check_all();
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1; model_reset(); #1;
        check_all();
        rst = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
